psum_acc_wb: RTL

//  Partial-sum accumulator and write-back stage directly downstream of the PE-array controller.

---
 rtl/pea_pkg.sv | 17 +
 rtl/psum_acc_wb_ofm_quant.sv | 39 +++
 rtl/psum_acc_wb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pea_pkg.sv
// Shared constants and types for the PE-array partial-sum path.
// Holds default geometry/widths and the write-back drain state encoding.
package pea_pkg;

  localparam int ROWS     = 8;
  localparam int TILE_LEN = 16;
  localparam int PSUM_W   = 20;
  localparam int ACC_W    = 32;
  localparam int OUT_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } drain_e;

endpackage

// File: rtl/psum_acc_wb_ofm_quant.sv
// ofm_quant: one-lane requantiser, acc -> round-half-up shift -> ReLU -> sat.
// Ports: acc_i (signed ACC_W), shift_i (0..31), relu_en_i, y_o (signed OUT_W).
module ofm_quant #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [4:0]       shift_i,
  input  logic             relu_en_i,
  output logic [OUT_W-1:0] y_o
);

  localparam logic signed [ACC_W:0] MAXV =
    (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] MINV =
    -(ACC_W+1)'(2**(OUT_W-1));

  logic        [ACC_W:0] rnd_w;
  logic signed [ACC_W:0] sum_w;
  logic signed [ACC_W:0] shr_w;

  // One extra bit so acc + rounding constant cannot wrap.
  always_comb begin
    rnd_w = '0;
    if (shift_i != 5'd0)
      rnd_w = (ACC_W+1)'(1) << (shift_i - 5'd1);
    sum_w = $signed({acc_i[ACC_W-1], acc_i}) + $signed(rnd_w);
    shr_w = sum_w >>> shift_i;
    if (relu_en_i && (shr_w < 0))
      shr_w = '0;
    if (shr_w > MAXV)
      y_o = MAXV[OUT_W-1:0];
    else if (shr_w < MINV)
      y_o = MINV[OUT_W-1:0];
    else
      y_o = shr_w[OUT_W-1:0];
  end

endmodule

// File: rtl/psum_acc_wb.sv
// psum_acc_wb: ping-pong partial-sum accumulator with requantising drain.
// In: pvalid/psum/row_mask/tag_first/tag_last/col_last/shift/relu_en/ofm_ready.
// Out: ofm_valid/ofm_data/ofm_mask/ofm_last, busy, sticky ovf_err.
module psum_acc_wb #(
  parameter int TILE_LEN = pea_pkg::TILE_LEN,
  parameter int ROWS     = pea_pkg::ROWS,
  parameter int PSUM_W   = pea_pkg::PSUM_W,
  parameter int ACC_W    = pea_pkg::ACC_W,
  parameter int OUT_W    = pea_pkg::OUT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pvalid,
  input  logic [ROWS*PSUM_W-1:0] psum,
  input  logic [ROWS-1:0]        row_mask,
  input  logic                   tag_first,
  input  logic                   tag_last,
  input  logic                   col_last,
  input  logic [4:0]             shift,
  input  logic                   relu_en,
  output logic                   ofm_valid,
  input  logic                   ofm_ready,
  output logic [ROWS*OUT_W-1:0]  ofm_data,
  output logic [ROWS-1:0]        ofm_mask,
  output logic                   ofm_last,
  output logic                   busy,
  output logic                   ovf_err
);

  import pea_pkg::*;

  localparam int CW = $clog2(TILE_LEN);
  localparam int WW = $clog2(TILE_LEN + 1);

  logic [ACC_W-1:0] mem_q [2][TILE_LEN][ROWS];
  logic [ACC_W-1:0] sx_w  [ROWS];

  logic            wr_bank_q;
  logic            rd_bank_q;
  logic [1:0]      full_q;
  logic [WW-1:0]   wr_col_q;
  logic [CW-1:0]   rd_col_q;
  logic [CW-1:0]   lastc_q [2];
  logic [ROWS-1:0] bmask_q [2];
  logic [ROWS-1:0] cmask_q;
  drain_e          state_q;

  logic            wr_full;
  logic            in_rng;
  logic            acc_we;
  logic            ovf_hit;
  logic            close_w;
  logic [CW-1:0]   wr_idx;
  logic [CW-1:0]   close_col;
  logic [ROWS-1:0] close_mask;
  logic [ROWS*OUT_W-1:0] q_w;

  // A full write bank blocks every beat, so a pass that trips the
  // overflow leaves the pending tile untouched and never closes.
  assign wr_full = full_q[wr_bank_q];
  assign in_rng  = wr_col_q < WW'(TILE_LEN);
  assign wr_idx  = wr_col_q[CW-1:0];
  assign acc_we  = pvalid & in_rng & ~wr_full;
  assign ovf_hit = pvalid & tag_first
                 & (wr_col_q == '0) & wr_full;
  assign close_w = pvalid & col_last & tag_last & ~wr_full;

  assign close_col  = in_rng ? wr_idx : CW'(TILE_LEN - 1);
  // Single-column tiles close on the beat that carries the mask.
  assign close_mask = (wr_col_q == '0) ? row_mask : cmask_q;

  assign busy = (|full_q) | (state_q != IDLE);

  always_comb begin
    for (int r = 0; r < ROWS; r++)
      sx_w[r] = {{(ACC_W-PSUM_W){psum[r*PSUM_W+PSUM_W-1]}},
                 psum[r*PSUM_W +: PSUM_W]};
  end

  always_ff @(posedge clk) begin
    if (acc_we) begin
      for (int r = 0; r < ROWS; r++) begin
        if (tag_first)
          mem_q[wr_bank_q][wr_idx][r] <= sx_w[r];
        else
          mem_q[wr_bank_q][wr_idx][r] <=
            mem_q[wr_bank_q][wr_idx][r] + sx_w[r];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_q
    ofm_quant #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
    ) u_q (
      .acc_i    (mem_q[rd_bank_q][rd_col_q][r]),
      .shift_i  (shift),
      .relu_en_i(relu_en),
      .y_o      (q_w[r*OUT_W +: OUT_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      wr_col_q   <= '0;
      rd_col_q   <= '0;
      cmask_q    <= '0;
      lastc_q[0] <= '0;
      lastc_q[1] <= '0;
      bmask_q[0] <= '0;
      bmask_q[1] <= '0;
      state_q    <= IDLE;
      ofm_valid  <= 1'b0;
      ofm_data   <= '0;
      ofm_mask   <= '0;
      ofm_last   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      if (pvalid) begin
        if (col_last)
          wr_col_q <= '0;
        else if (in_rng)
          wr_col_q <= wr_col_q + WW'(1);
        if (wr_col_q == '0)
          cmask_q <= row_mask;
      end

      if (ovf_hit)
        ovf_err <= 1'b1;

      if (close_w) begin
        full_q[wr_bank_q]  <= 1'b1;
        lastc_q[wr_bank_q] <= close_col;
        bmask_q[wr_bank_q] <= close_mask;
        wr_bank_q          <= ~wr_bank_q;
      end

      // Release clears the read bank; a close only ever sets the
      // other (empty) bank, so both can land in the same cycle.
      unique case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q])
            state_q <= LOAD;
        end
        LOAD: begin
          ofm_data  <= q_w;
          ofm_mask  <= bmask_q[rd_bank_q];
          ofm_last  <= rd_col_q == lastc_q[rd_bank_q];
          ofm_valid <= 1'b1;
          state_q   <= HOLD;
        end
        HOLD: begin
          if (ofm_ready) begin
            ofm_valid <= 1'b0;
            if (ofm_last) begin
              full_q[rd_bank_q] <= 1'b0;
              rd_bank_q         <= ~rd_bank_q;
              rd_col_q          <= '0;
              state_q           <= IDLE;
            end else begin
              rd_col_q <= rd_col_q + CW'(1);
              state_q  <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
